// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared MIPS definitions for the fetch stage: fetch FSM state encodings,
//   the NOP encoding, the default reset vector, the redirect-select type and
//   a word-alignment helper.
//   Optional feature macro used by importers: FETCH_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    // Fetch FSM state encodings. FETCH_HALT is only reachable when the
    // alignment check is compiled in.
    localparam logic [1:0] FETCH_BOOT = 2'd0;
    localparam logic [1:0] FETCH_RUN  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;
    localparam logic [1:0] FETCH_HALT = 2'd3;

    // sll $0,$0,0
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Default reset vector (first fetch address).
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // Which redirect (if any) decode is requesting this cycle.
    typedef enum logic [1:0] {
        TGT_NONE   = 2'd0,
        TGT_JR     = 2'd1,
        TGT_JUMP   = 2'd2,
        TGT_BRANCH = 2'd3
    } tgt_sel_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// -----------------------------------------------------------------------------
// fetch_target_calc
//   Purely combinational redirect-target computation for the fetch stage.
//   Priority: JR > J-type jump > taken branch. The raw target is returned
//   unaligned so the caller can decide whether to flag or clear bits [1:0].
//
//   Ports:
//     pc_id           in  32  PC of the instruction in decode
//     instr_id        in  26  index/immediate field of the instruction in decode
//     jr_pc           in  32  forwarded rs value for JR
//     jump_reg        in  1   JR requested
//     jump_target     in  1   J-type jump requested
//     jump_branch     in  1   conditional branch taken
//     redirect_target out 32  selected target (raw)
//     redirect_sel    out     which redirect was selected (TGT_NONE if none)
// -----------------------------------------------------------------------------
module fetch_target_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_id,
    input  logic [25:0] instr_id,
    input  logic [31:0] jr_pc,
    input  logic        jump_reg,
    input  logic        jump_target,
    input  logic        jump_branch,
    output logic [31:0] redirect_target,
    output tgt_sel_t    redirect_sel
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;

    assign pc_plus4 = pc_id + 32'd4;

    // Branch offset: sign-extended immediate shifted left by two.
    assign br_offset[17:0] = {instr_id[15:0], 2'b00};
    generate
        for (genvar gi = 18; gi < 32; gi++) begin : g_br_sext
            assign br_offset[gi] = instr_id[15];
        end
    endgenerate

    // J-type target keeps the 256 MB region of the delay-slot PC.
    assign jump_addr   = {pc_plus4[31:28], instr_id[25:0], 2'b00};
    assign branch_addr = pc_plus4 + br_offset;

    always_comb begin
        redirect_target = pc_plus4;
        redirect_sel    = TGT_NONE;
        if (jump_reg) begin
            redirect_target = jr_pc;
            redirect_sel    = TGT_JR;
        end else if (jump_target) begin
            redirect_target = jump_addr;
            redirect_sel    = TGT_JUMP;
        end else if (jump_branch) begin
            redirect_target = branch_addr;
            redirect_sel    = TGT_BRANCH;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 5-stage MIPS pipeline. Owns the fetch PC,
//   drives a synchronous-read instruction memory (data one cycle after the
//   read strobe), presents pc_id/instr_id to decode and holds them across
//   decode stalls. Redirects from decode follow delay-slot semantics: the
//   fetch already in flight (pc_id+4) always completes, and the redirect
//   replaces the fetch after it.
//
//   Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
//   targets (sticky fetch_fault, HALT state). Without it, target bits [1:0]
//   are cleared silently and fetch_fault is constant 0.
//
//   Ports:
//     clk          in  1   clock, rising edge
//     rst          in  1   synchronous active-high reset
//     stall        in  1   decode cannot accept a new instruction
//     jump_branch  in  1   conditional branch taken (decode)
//     jump_target  in  1   J-type jump (decode)
//     jump_reg     in  1   JR (decode)
//     jr_pc        in  32  forwarded rs for JR
//     imem_addr    out 32  fetch byte address (= pc_f register)
//     imem_rd_en   out 1   instruction memory read strobe
//     imem_data    in  32  registered instruction memory output
//     pc_id        out 32  PC of instruction in decode
//     instr_id     out 32  instruction in decode (NOP when not valid)
//     instr_valid  out 1   instr_id is a real instruction
//     fetch_fault  out 1   sticky misaligned-target flag
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid,
    output logic        fetch_fault
);

    logic [1:0]  state_reg,       state_next;
    logic [31:0] pc_f_reg,        pc_f_next;
    logic [31:0] pc_id_reg,       pc_id_next;
    logic        instr_valid_reg, instr_valid_next;
    logic [31:0] hold_reg,        hold_next;

    logic [31:0] redirect_target;
    tgt_sel_t    redirect_sel;
    logic        redirect_taken;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr   = pc_f_reg;
    assign pc_id       = pc_id_reg;
    assign instr_valid = instr_valid_reg;

    // While stalled the memory keeps re-reading pc_f, so the instruction
    // owned by decode lives in hold_reg for the whole HOLD period.
    always_comb begin
        instr_id = NOP;
        if (instr_valid_reg) begin
            instr_id = (state_reg == FETCH_HOLD) ? hold_reg : imem_data;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_reg, fault_next;
    logic target_misaligned;

    assign fetch_fault       = fault_reg;
    assign imem_rd_en        = !rst && (state_reg != FETCH_HALT);
    assign target_misaligned = redirect_taken && (redirect_target[1:0] != 2'b00);
`else
    assign fetch_fault = 1'b0;
    assign imem_rd_en  = !rst;
`endif

    // ------------------------------------------------------------------
    // Redirect target from the instruction currently in decode
    // ------------------------------------------------------------------
    fetch_target_calc u_target_calc (
        .pc_id           (pc_id_reg),
        .instr_id        (instr_id[25:0]),
        .jr_pc           (jr_pc),
        .jump_reg        (jump_reg),
        .jump_target     (jump_target),
        .jump_branch     (jump_branch),
        .redirect_target (redirect_target),
        .redirect_sel    (redirect_sel)
    );

    assign redirect_taken = (redirect_sel != TGT_NONE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_f_next        = pc_f_reg;
        pc_id_next       = pc_id_reg;
        instr_valid_next = instr_valid_reg;
        hold_next        = hold_reg;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_next       = fault_reg;
`endif

        case (state_reg)
            FETCH_BOOT: begin
                // Reset-vector fetch is in flight; stall and redirects are
                // meaningless here because decode holds no instruction.
                pc_f_next        = RESET_PC + 32'd4;
                pc_id_next       = RESET_PC;
                instr_valid_next = 1'b1;
                state_next       = FETCH_RUN;
            end

            FETCH_RUN, FETCH_HOLD: begin
                if (stall) begin
                    // Only the first stall cycle captures memory data; after
                    // that imem_data reflects the re-read of pc_f instead.
                    if (state_reg == FETCH_RUN) begin
                        hold_next  = imem_data;
                        state_next = FETCH_HOLD;
                    end
                end else begin
                    // Advance: the in-flight fetch (pc_f) moves to decode;
                    // a redirect replaces the fetch after the delay slot.
                    pc_id_next       = pc_f_reg;
                    instr_valid_next = 1'b1;
                    state_next       = FETCH_RUN;
                    if (redirect_taken) begin
                        pc_f_next = word_align(redirect_target);
                    end else begin
                        pc_f_next = pc_f_reg + 32'd4;
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    if (target_misaligned) begin
                        pc_id_next       = pc_id_reg;
                        instr_valid_next = 1'b0;
                        fault_next       = 1'b1;
                        state_next       = FETCH_HALT;
                    end
`endif
                end
            end

`ifdef FETCH_ALIGN_CHECK_EN
            FETCH_HALT: begin
                // Parked until reset.
                instr_valid_next = 1'b0;
            end
`endif

            default: begin
                state_next = FETCH_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH_BOOT;
            pc_f_reg        <= RESET_PC;
            pc_id_reg       <= 32'd0;
            instr_valid_reg <= 1'b0;
            hold_reg        <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_f_reg        <= pc_f_next;
            pc_id_reg       <= pc_id_next;
            instr_valid_reg <= instr_valid_next;
            hold_reg        <= hold_next;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A driver applies one vector per cycle and
//   pushes the expected decode/fetch outputs for that cycle into a queue; a
//   monitor on the falling edge pops and compares. The instruction memory is
//   a synchronous-read model returning addr>>2 except for a few planted
//   branch/jump encodings.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump_branch = 1'b0;
    logic        jump_target = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_pc = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        instr_valid;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .jr_pc       (jr_pc),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_data   (imem_data),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0040: return 32'h1000_FFFC;   // beq, imm = -4
            32'h1000_0000: return 32'h0800_0010;   // j, index = 0x10
            default:       return addr >> 2;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem_word(imem_addr);
    end

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc_id;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        rd_en;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Monitor: one popped expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            bit   bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if (instr_valid !== e.valid || pc_id !== e.pc_id || instr_id !== e.instr ||
                imem_addr !== e.addr || imem_rd_en !== e.rd_en || fetch_fault !== e.fault)
                bad = 1'b1;
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got valid=%0b pc_id=%h instr=%h addr=%h rd_en=%0b fault=%0b, want valid=%0b pc_id=%h instr=%h addr=%h rd_en=%0b fault=%0b",
                         e.name, instr_valid, pc_id, instr_id, imem_addr, imem_rd_en, fetch_fault,
                         e.valid, e.pc_id, e.instr, e.addr, e.rd_en, e.fault);
            end else begin
                $display("ok   %s: valid=%0b pc_id=%h instr=%h addr=%h rd_en=%0b fault=%0b",
                         e.name, instr_valid, pc_id, instr_id, imem_addr, imem_rd_en, fetch_fault);
            end
        end
    end

    // Drive inputs for the coming edge and expect the outputs of this cycle.
    task automatic step(input string name, input logic r, input logic s,
                        input logic b, input logic t, input logic j, input logic [31:0] jp,
                        input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                        input logic [31:0] ea, input logic erd, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; jump_branch = b; jump_target = t; jump_reg = j; jr_pc = jp;
        e.name = name; e.valid = ev; e.pc_id = epc; e.instr = ei;
        e.addr = ea; e.rd_en = erd; e.fault = ef;
        exp_q.push_back(e);
    endtask

    // Plain sequential cycle with pc_id = p and no redirect.
    task automatic seq(input string name, input logic [31:0] p);
        step(name, 0, 0, 0, 0, 0, 32'd0, 1, p, mem_word(p), p + 32'd4, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and boot
        step("reset",  1, 0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
        step("boot",   0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 1, 0);
        seq("first",  32'h0);
        seq("seq4",   32'h4);
        // Stall three cycles with pc_id = 8
        step("stall0", 0, 1, 0, 0, 0, 32'd0, 1, 32'h8, 32'h2, 32'hC, 1, 0);
        step("stall1", 0, 1, 0, 0, 0, 32'd0, 1, 32'h8, 32'h2, 32'hC, 1, 0);
        step("stall2", 0, 1, 0, 0, 0, 32'd0, 1, 32'h8, 32'h2, 32'hC, 1, 0);
        step("release",0, 0, 0, 0, 0, 32'd0, 1, 32'h8, 32'h2, 32'hC, 1, 0);
        for (int p = 32'hC; p < 32'h40; p += 4) seq("run", p);
        // Taken branch at 0x40, imm = -4 -> target 0x34
        step("branch", 0, 0, 1, 0, 0, 32'd0, 1, 32'h40, 32'h1000_FFFC, 32'h44, 1, 0);
        step("br_slot",0, 0, 0, 0, 0, 32'd0, 1, 32'h44, 32'h11, 32'h34, 1, 0);
        step("br_tgt", 0, 0, 0, 0, 0, 32'd0, 1, 32'h34, 32'hD, 32'h38, 1, 0);
        // JR held off by stall, then taken with a fresh jr_pc
        step("jr_st0", 0, 1, 0, 0, 1, 32'hDEAD, 1, 32'h38, 32'hE, 32'h3C, 1, 0);
        step("jr_st1", 0, 1, 0, 0, 1, 32'hDEAD, 1, 32'h38, 32'hE, 32'h3C, 1, 0);
        step("jr_go",  0, 0, 0, 0, 1, 32'h100, 1, 32'h38, 32'hE, 32'h3C, 1, 0);
        step("jr_slot",0, 0, 0, 0, 0, 32'd0, 1, 32'h3C, 32'hF, 32'h100, 1, 0);
        // JR to 0x1000_0000 to set up the J-type test
        step("jr_far", 0, 0, 0, 0, 1, 32'h1000_0000, 1, 32'h100, 32'h40, 32'h104, 1, 0);
        step("jf_slot",0, 0, 0, 0, 0, 32'd0, 1, 32'h104, 32'h41, 32'h1000_0000, 1, 0);
        step("jump",   0, 0, 0, 1, 0, 32'd0, 1, 32'h1000_0000, 32'h0800_0010, 32'h1000_0004, 1, 0);
        step("j_slot", 0, 0, 0, 0, 0, 32'd0, 1, 32'h1000_0004, 32'h0400_0001, 32'h1000_0040, 1, 0);
        // Misaligned JR from pc_id = 0x1000_0040
        step("jr_mis", 0, 0, 0, 0, 1, 32'h102, 1, 32'h1000_0040, 32'h0400_0010, 32'h1000_0044, 1, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        step("halt0",  0, 0, 0, 0, 0, 32'd0, 0, 32'h1000_0040, 32'h0, 32'h100, 0, 1);
        step("halt1",  0, 0, 0, 0, 0, 32'd0, 0, 32'h1000_0040, 32'h0, 32'h100, 0, 1);
        step("halt_rst",1, 0, 0, 0, 0, 32'd0, 0, 32'h1000_0040, 32'h0, 32'h100, 0, 1);
`else
        step("mis_slot",0, 0, 0, 0, 0, 32'd0, 1, 32'h1000_0044, 32'h0400_0011, 32'h100, 1, 0);
        step("mis_tgt", 0, 0, 0, 0, 0, 32'd0, 1, 32'h100, 32'h40, 32'h104, 1, 0);
        step("mid_rst", 1, 0, 0, 0, 0, 32'd0, 1, 32'h104, 32'h41, 32'h108, 0, 0);
`endif
        // Reset mid-operation discards everything
        step("reboot", 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 1, 0);
        seq("refirst", 32'h0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
